fp_mul: RTL and testbench
=========================

# fp_mul

Combinational IEEE-754 binary16 (half-precision) multiplier with a registered result. It is the multiply unit of the ALU's floating-point datapath. It takes two half-precision operands and produces their correctly rounded product one clock later. It handles normal and subnormal operands, gradual underflow, overflow to infinity, and IEEE special values.

## Interface
- No parameters; format fixed at binary16: 1 sign, 5 exponent (bias 15), 10 fraction bits.
- clk_i  input  1  clock; result register updates on rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- opA_i  input  16  operand A, binary16.
- opB_i  input  16  operand B, binary16.
- MUL_o  output  16  registered product A×B, binary16.
- Internal probe signals, required by name for hierarchical access by verification:
  - Exp: signed 7-bit, combinational.
  - DNshamt: 5-bit, combinational.

## Operation
- Sign: result sign = signA XOR signB, for all results including zero, infinity and overflow.
- Operand unpack:
  - Normal operand (e = 1..30): significand 1.f, effective exponent e.
  - Subnormal operand (e = 0, f ≠ 0): left-normalize 0.f by its leading-zero count z; effective exponent 1−z−1 = −z.
  - Example: 0x0001 has effective exponent −9 with significand 1.0.
- Multiply: 11b×11b significands give a 22-bit product. If the product is ≥ 2.0, shift right 1 and add 1 to the exponent.
- Exp = effA + effB − 15 + norm_adjust: the biased result exponent before underflow handling. Range −33..46 fits signed 7 bits.
- Underflow handling:
  - If Exp ≤ 0, DNshamt = min(1 − Exp, 31). Shift the significand right by DNshamt, collecting sticky bits, and set the result exponent field to 0.
  - Otherwise DNshamt = 0.
- Rounding: round-to-nearest-even using guard, round and sticky bits.
  - Mantissa carry-out after rounding increments the exponent.
  - A subnormal that rounds up to 1.0×2^−14 becomes exponent field 1.
- Overflow: a final biased exponent ≥ 31 gives ±infinity (exp 11111, frac 0).
- Underflow: a result below half the minimum subnormal rounds to ±0.
- Special values, priority order:
  1. Any NaN input, or infinity × zero → canonical qNaN 0x7E00 (sign 0).
  2. Infinity × nonzero → ±infinity (0x7C00 | sign).
  3. Zero × finite → ±zero.
- Exp and DNshamt are don't-care for special-value cases.

## Timing
- Unpack, multiply, normalize, round and special-case logic form one combinational path from opA_i/opB_i to the D input of a 16-bit result register.
- Latency is 1 cycle: MUL_o on the edge after operands are presented reflects those operands. Throughput is one operation per cycle; no handshake.
- Exp and DNshamt follow the current inputs with no latency.
- Reset: rstn_i low clears MUL_o to 0x0000 immediately, independent of clk_i.
  - While reset is held, MUL_o stays 0x0000.
  - The first capture occurs on the first rising edge after rstn_i deasserts.
  - A reset asserted mid-stream discards the pending result.

## Test plan
Each case holds operands for one cycle and checks MUL_o on the following edge. Exp and DNshamt are checked combinationally.
- Normal×normal:
  - 0x5380×0x4F00 (60×28) → MUL_o = 0x6690, Exp = 25, DNshamt = 0.
  - 0x4400×0x4000 → 0x4800, Exp = 18.
  - 0x4200×0x4500 (3×5) → 0x4B80, Exp = 18.
  - 0x4200×0x3000 (3×0.125) → 0x3600, Exp = 13.
- Normal×subnormal, subnormal results:
  - 0x4200×0x0001 → 0x0003, Exp = −8, DNshamt = 9.
  - 0x4400×0x0080 → 0x0200.
  - 0x4200×0x0100 → 0x0300.
  - 0x4200×0x0010 → 0x0030.
  - 0x4100×0x0008 → 0x0014.
- Overflow/underflow/rounding:
  - 0x7BFF×0x4000 → 0x7C00.
  - 0x0001×0x3800 → 0x0000 (tie to even).
  - 0x0001×0x3A00 → 0x0001.
  - 0x3C01×0x3C01 → 0x3C02.
- Specials and sign:
  - 0x7C00×0x0000 → 0x7E00.
  - 0x7E00×0x3C00 → 0x7E00.
  - 0xFC00×0x4000 → 0xFC00.
  - 0x8000×0x4000 → 0x8000.
  - 0xC000×0x4200 → 0xC600.
- Reset: drive 0x4400×0x4000, assert rstn_i low between edges → MUL_o goes to 0x0000 at once. Release reset → 0x4800 appears on the next edge.

Source files
------------

// File: rtl/fp_mul.sv
// IEEE-754 binary16 multiplier: unpack, multiply, normalize, round-to-nearest-even
// and special-value handling in one combinational path into a 16-bit result register.
module fp_mul (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [15:0] opA_i,
   input  logic [15:0] opB_i,
   output logic [15:0] MUL_o
);

   logic signed [6:0] Exp;
   logic [4:0]        DNshamt;

   logic [15:0] op [2];
   assign op[0] = opA_i;
   assign op[1] = opB_i;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         logic [4:0]        e;
         logic [9:0]        f;
         logic [3:0]        lz;
         logic [10:0]       sig;
         logic signed [6:0] eff_exp;
         logic              is_nan;
         logic              is_inf;
         logic              is_zero;

         assign e       = op[gi][14:10];
         assign f       = op[gi][9:0];
         assign is_nan  = (e == 5'd31) && (f != 10'd0);
         assign is_inf  = (e == 5'd31) && (f == 10'd0);
         assign is_zero = (e == 5'd0)  && (f == 10'd0);

         // Leading-zero count of the fraction; the highest set bit wins.
         always_comb begin
            lz = 4'd0;
            for (int i = 0; i <= 9; i++) begin
               if (f[i]) lz = 4'(9 - i);
            end
         end

         // Subnormals are left-normalized so every significand has a hidden 1 at bit 10.
         always_comb begin
            if (e == 5'd0) begin
               sig     = {f, 1'b0} << lz;
               eff_exp = 7'sd0 - $signed({3'b000, lz});
            end else begin
               sig     = {1'b1, f};
               eff_exp = $signed({2'b00, e});
            end
         end
      end
   endgenerate

   logic [21:0] prod;
   logic [21:0] norm;
   logic        adj;

   assign prod = {11'd0, g_unpack[0].sig} * {11'd0, g_unpack[1].sig};
   assign adj  = prod[21];
   assign norm = adj ? prod : {prod[20:0], 1'b0};
   assign Exp  = g_unpack[0].eff_exp + g_unpack[1].eff_exp - 7'sd15 + $signed({6'd0, adj});

   logic signed [6:0] dn_full;
   assign dn_full = 7'sd1 - Exp;

   always_comb begin
      DNshamt = 5'd0;
      if (Exp <= 7'sd0) begin
         DNshamt = (dn_full > 7'sd31) ? 5'd31 : dn_full[4:0];
      end
   end

   // Denormalizing shift; bits pushed below the 32-bit window feed the sticky bit.
   logic [31:0] ext;
   logic [31:0] shifted;
   logic        lost;
   logic        guard_bit;
   logic        round_bit;
   logic        sticky_bit;
   logic        round_up;

   assign ext        = {10'd0, norm};
   assign shifted    = ext >> DNshamt;
   assign lost       = |(ext & ~(32'hFFFF_FFFF << DNshamt));
   assign guard_bit  = shifted[10];
   assign round_bit  = shifted[9];
   assign sticky_bit = (|shifted[8:0]) | lost;
   assign round_up   = guard_bit & (round_bit | sticky_bit | shifted[11]);

   // Fraction carry ripples into the exponent field, which also turns a
   // subnormal that rounds up to 2^-14 into exponent field 1.
   logic [5:0]  biased;
   logic [16:0] total;
   logic        ovf;

   assign biased = (Exp > 7'sd0) ? Exp[5:0] : 6'd0;
   assign total  = {1'b0, biased, shifted[20:11]} + {16'd0, round_up};
   assign ovf    = (total[16:10] >= 7'd31);

   logic        sign_r;
   logic        any_nan;
   logic        any_inf;
   logic        any_zero;
   logic [15:0] mul_next;

   assign sign_r   = opA_i[15] ^ opB_i[15];
   assign any_nan  = g_unpack[0].is_nan | g_unpack[1].is_nan;
   assign any_inf  = g_unpack[0].is_inf | g_unpack[1].is_inf;
   assign any_zero = g_unpack[0].is_zero | g_unpack[1].is_zero;

   always_comb begin
      mul_next = {sign_r, total[14:0]};
      if (any_nan || (any_inf && any_zero)) begin
         mul_next = 16'h7E00;
      end else if (any_inf) begin
         mul_next = {sign_r, 15'h7C00};
      end else if (any_zero) begin
         mul_next = {sign_r, 15'h0000};
      end else if (ovf) begin
         mul_next = {sign_r, 15'h7C00};
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         MUL_o <= 16'h0000;
      end else begin
         MUL_o <= mul_next;
      end
   end

endmodule

// File: tb/tb_fp_mul.sv
// Self-checking bench for fp_mul: directed cases, random operands against a
// real-arithmetic binary16 reference model, back-to-back streaming and reset.
module tb_fp_mul;

   logic        clk;
   logic        rstn;
   logic [15:0] opa;
   logic [15:0] opb;
   logic [15:0] mul;

   int n_checks = 0;
   int n_pass   = 0;

   fp_mul dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .opA_i  (opa),
      .opB_i  (opb),
      .MUL_o  (mul)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic real pow2(input int k);
      real r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else        for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real h2r(input logic [15:0] h);
      int  e = int'(h[14:10]);
      int  f = int'(h[9:0]);
      real v;
      if (e == 0) v = real'(f) * pow2(-24);
      else        v = real'(1024 + f) * pow2(e - 25);
      return v;
   endfunction

   function automatic real rne(input real x);
      real fl = $floor(x);
      real d  = x - fl;
      if (d > 0.5) return fl + 1.0;
      if (d == 0.5) return ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
      return fl;
   endfunction

   function automatic int flog2(input real m);
      int  e = 0;
      real x = m;
      while (x >= 2.0) begin x = x / 2.0; e++; end
      while (x < 1.0)  begin x = x * 2.0; e--; end
      return e;
   endfunction

   function automatic bit is_nan(input logic [15:0] h);
      return (h[14:10] == 5'd31) && (h[9:0] != 10'd0);
   endfunction
   function automatic bit is_inf(input logic [15:0] h);
      return (h[14:10] == 5'd31) && (h[9:0] == 10'd0);
   endfunction
   function automatic bit is_zero(input logic [15:0] h);
      return h[14:0] == 15'd0;
   endfunction
   function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
      return is_nan(a) || is_nan(b) || is_inf(a) || is_inf(b) || is_zero(a) || is_zero(b);
   endfunction

   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic s = a[15] ^ b[15];
      real  m;
      real  sg;
      int   e;
      int   n;
      if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a)))
         return 16'h7E00;
      if (is_inf(a) || is_inf(b)) return {s, 15'h7C00};
      if (is_zero(a) || is_zero(b)) return {s, 15'h0000};
      m = h2r(a) * h2r(b);
      e = flog2(m);
      if (e < -14) begin
         n = $rtoi(rne(m * pow2(24)));
         return {s, 15'(n)};
      end
      sg = rne(m * pow2(10 - e));
      if (sg >= 2048.0) begin sg = 1024.0; e++; end
      if (e + 15 >= 31) return {s, 15'h7C00};
      n = $rtoi(sg) - 1024;
      return {s, 5'(e + 15), 10'(n)};
   endfunction

   // Biased exponent of the exact product before underflow handling.
   function automatic int ref_exp(input logic [15:0] a, input logic [15:0] b);
      return flog2(h2r(a) * h2r(b)) + 15;
   endfunction

   function automatic int ref_dn(input int ex);
      if (ex > 0) return 0;
      return (1 - ex > 31) ? 31 : 1 - ex;
   endfunction

   function automatic logic [15:0] rand_op();
      logic [15:0] v = 16'($urandom);
      case ($urandom_range(0, 3))
         0: v[14:10] = 5'd0;
         1: v[14:10] = 5'($urandom_range(1, 6));
         2: v[14:10] = 5'($urandom_range(24, 30));
         default: ;
      endcase
      return v;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 1'b0;
      opa  = 16'h4400;
      opb  = 16'h4000;
      #1;
      n_checks++;
      if (mul !== 16'h0000) $display("FAIL reset_init: MUL_o=%h want 0000", mul);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (mul !== 16'h0000) $display("FAIL reset_held: MUL_o=%h want 0000", mul);
      else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (mul !== 16'h4800) $display("FAIL reset_first_capture: MUL_o=%h want 4800", mul);
      else n_pass++;
      $display("reset: init/held/first capture MUL_o=%h", mul);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      bit          has_exp;
      int          ex;
   } vec_t;

   task automatic test_directed();
      vec_t v [18];
      v[0]  = '{16'h5380, 16'h4F00, 16'h6690, 1, 25};
      v[1]  = '{16'h4400, 16'h4000, 16'h4800, 1, 18};
      v[2]  = '{16'h4200, 16'h4500, 16'h4B80, 1, 18};
      v[3]  = '{16'h4200, 16'h3000, 16'h3600, 1, 13};
      v[4]  = '{16'h4200, 16'h0001, 16'h0003, 1, -8};
      v[5]  = '{16'h4400, 16'h0080, 16'h0200, 0, 0};
      v[6]  = '{16'h4200, 16'h0100, 16'h0300, 0, 0};
      v[7]  = '{16'h4200, 16'h0010, 16'h0030, 0, 0};
      v[8]  = '{16'h4100, 16'h0008, 16'h0014, 0, 0};
      v[9]  = '{16'h7BFF, 16'h4000, 16'h7C00, 0, 0};
      v[10] = '{16'h0001, 16'h3800, 16'h0000, 0, 0};
      v[11] = '{16'h0001, 16'h3A00, 16'h0001, 0, 0};
      v[12] = '{16'h3C01, 16'h3C01, 16'h3C02, 0, 0};
      v[13] = '{16'h7C00, 16'h0000, 16'h7E00, 0, 0};
      v[14] = '{16'h7E00, 16'h3C00, 16'h7E00, 0, 0};
      v[15] = '{16'hFC00, 16'h4000, 16'hFC00, 0, 0};
      v[16] = '{16'h8000, 16'h4000, 16'h8000, 0, 0};
      v[17] = '{16'hC000, 16'h4200, 16'hC600, 0, 0};
      foreach (v[i]) begin
         @(negedge clk);
         opa = v[i].a;
         opb = v[i].b;
         #1;
         if (v[i].has_exp) begin
            n_checks++;
            if (int'(dut.Exp) !== v[i].ex)
               $display("FAIL directed_exp %0d: Exp=%0d want %0d", i, dut.Exp, v[i].ex);
            else n_pass++;
            n_checks++;
            if (int'(dut.DNshamt) !== ref_dn(v[i].ex))
               $display("FAIL directed_dnshamt %0d: DNshamt=%0d want %0d", i, dut.DNshamt, ref_dn(v[i].ex));
            else n_pass++;
         end
         @(posedge clk); #1;
         n_checks++;
         if (mul !== v[i].res)
            $display("FAIL directed_mul %0d: %h*%h MUL_o=%h want %h", i, v[i].a, v[i].b, mul, v[i].res);
         else n_pass++;
         $display("directed %0d: %h*%h -> %h", i, v[i].a, v[i].b, mul);
      end
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] want;
      int          ex;
      for (int i = 0; i < 400; i++) begin
         a = rand_op();
         b = rand_op();
         want = ref_mul(a, b);
         @(negedge clk);
         opa = a;
         opb = b;
         #1;
         if (!is_special(a, b)) begin
            ex = ref_exp(a, b);
            n_checks++;
            if (int'(dut.Exp) !== ex)
               $display("FAIL random_exp %0d: %h*%h Exp=%0d want %0d", i, a, b, dut.Exp, ex);
            else n_pass++;
            n_checks++;
            if (int'(dut.DNshamt) !== ref_dn(ex))
               $display("FAIL random_dnshamt %0d: %h*%h DNshamt=%0d want %0d", i, a, b, dut.DNshamt, ref_dn(ex));
            else n_pass++;
         end
         @(posedge clk); #1;
         n_checks++;
         if (mul !== want)
            $display("FAIL random_mul %0d: %h*%h MUL_o=%h want %h", i, a, b, mul, want);
         else n_pass++;
         $display("random %0d: %h*%h -> %h", i, a, b, mul);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] pa;
      logic [15:0] pb;
      logic [15:0] want;
      @(negedge clk);
      pa = rand_op();
      pb = rand_op();
      opa = pa;
      opb = pb;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         want = ref_mul(pa, pb);
         n_checks++;
         if (mul !== want)
            $display("FAIL b2b_mul %0d: %h*%h MUL_o=%h want %h", i, pa, pb, mul, want);
         else n_pass++;
         $display("b2b %0d: %h*%h -> %h", i, pa, pb, mul);
         pa = rand_op();
         pb = rand_op();
         opa = pa;
         opb = pb;
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      opa = 16'h4200;
      opb = 16'h4500;
      @(posedge clk); #1;
      n_checks++;
      if (mul !== 16'h4B80) $display("FAIL mid_pre: MUL_o=%h want 4b80", mul);
      else n_pass++;
      // New operands pending, reset lands before the edge that would capture them.
      opa = 16'h4400;
      opb = 16'h4000;
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if (mul !== 16'h0000) $display("FAIL mid_async_clear: MUL_o=%h want 0000", mul);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (mul !== 16'h0000) $display("FAIL mid_discard: MUL_o=%h want 0000", mul);
      else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      #1;
      n_checks++;
      if (mul !== 16'h0000) $display("FAIL mid_release_hold: MUL_o=%h want 0000", mul);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (mul !== 16'h4800) $display("FAIL mid_recover: MUL_o=%h want 4800", mul);
      else n_pass++;
      $display("midstream reset: recovered MUL_o=%h", mul);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
